// File: rtl/ring_arbiter.sv
// Round-robin arbiter with a one-hot ring pointer and a registered one-hot grant.
// Define ARB_TIMEOUT_EN to force a release after MAX_HOLD grant cycles.
module ring_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 r,
  input  logic [N-1:0]         req,
  input  logic                 done,
  output logic [N-1:0]         gnt,
  output logic                 gnt_vld,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic [N-1:0]         ptr,
  output logic                 tout
);
  // state | meaning
  // IDLE  | no grant held; lowest ring distance from ptr wins on the next edge
  // GRANT | gnt held until done, owner drops req, or hold limit

  localparam int IW = $clog2(N);
  localparam logic [IW:0] N_W = (IW+1)'(N);

  if (N < 2 || N > 16) begin : g_bad_n
    $error("ring_arbiter: N must be 2..16");
  end
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
    $error("ring_arbiter: MAX_HOLD must be 1..255");
  end

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state, state_d;
  logic [N-1:0]  gnt_d, ptr_d;
  logic [IW-1:0] gnt_id_d;
  logic          tout_d;

  logic [2*N-1:0] req2;
  logic [N-1:0]   req_rot;
  logic [IW-1:0]  ptr_idx, off, sel_id;
  logic [IW:0]    sum;
  logic           rel, force_rel;

  // Rotate requests so the pointer position sits at bit 0, then take the lowest set bit.
  always_comb begin
    ptr_idx = '0;
    for (int i = 0; i < N; i++)
      if (ptr[i]) ptr_idx = IW'(i);
    req2    = {req, req};
    req_rot = req2[ptr_idx +: N];
    off     = '0;
    for (int i = N-1; i >= 0; i--)
      if (req_rot[i]) off = IW'(i);
    sum    = {1'b0, ptr_idx} + {1'b0, off};
    sel_id = (sum >= N_W) ? IW'(sum - N_W) : sum[IW-1:0];
  end

  assign rel = done | ~req[gnt_id];

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold_cnt;

  always_ff @(posedge clk) begin
    if (r || state == IDLE) hold_cnt <= '0;
    else                    hold_cnt <= hold_cnt + 8'd1;
  end

  // A release in the limit cycle wins, so done there is a normal release.
  assign force_rel = (state == GRANT) && (hold_cnt == HOLD_LAST) && !rel;
`else
  assign force_rel = 1'b0;
`endif

  always_comb begin
    state_d  = state;
    gnt_d    = gnt;
    gnt_id_d = gnt_id;
    ptr_d    = ptr;
    tout_d   = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          state_d  = GRANT;
          gnt_d    = {{(N-1){1'b0}}, 1'b1} << sel_id;
          gnt_id_d = sel_id;
        end
      end
      GRANT: begin
        if (rel || force_rel) begin
          state_d  = IDLE;
          gnt_d    = '0;
          gnt_id_d = '0;
          ptr_d    = {gnt[N-2:0], gnt[N-1]};
          tout_d   = force_rel;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (r) begin
      state  <= IDLE;
      gnt    <= '0;
      gnt_id <= '0;
      ptr    <= {{(N-1){1'b0}}, 1'b1};
      tout   <= 1'b0;
    end else begin
      state  <= state_d;
      gnt    <= gnt_d;
      gnt_id <= gnt_id_d;
      ptr    <= ptr_d;
      tout   <= tout_d;
    end
  end

  assign gnt_vld = |gnt;

endmodule
